// File: rtl/demux16_deser.sv
// demux16_deser
// -------------
// 1-to-WIDTH demultiplexing deserializer. Each accepted (sel, din) pair
// writes din into bit sel of an assembly register. When every bit position
// of the current frame has been written, the rebuilt word is offered on a
// valid/ready handshake. It is held there until the consumer takes it.
//
// Ports:
//   clk        - rising-edge clock
//   rst        - synchronous, active-high reset
//   din        - serial data bit
//   sel        - destination bit index for din
//   din_valid  - din/sel valid this cycle
//   din_ready  - block accepts din/sel this cycle (combinational from state)
//   word       - assembled word
//   word_valid - word complete and held stable
//   word_ready - downstream consumes word
//   fill_mask  - bit i set once position i has been written this frame
//   dup_err    - one-cycle pulse when a filled position is rewritten
module demux16_deser #(
  parameter int WIDTH = 16,
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic [SEL_W-1:0] sel,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [WIDTH-1:0] word,
  output logic             word_valid,
  input  logic             word_ready,
  output logic [WIDTH-1:0] fill_mask,
  output logic             dup_err
);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] word_reg;
  logic [WIDTH-1:0] fill_mask_reg;
  logic             word_valid_reg;
  logic             dup_err_reg;

  logic [WIDTH-1:0] sel_onehot;
  logic [WIDTH-1:0] word_next;
  logic [WIDTH-1:0] fill_mask_next;
  logic             accept;
  logic             frame_done;

  // Per-bit decode of sel and the candidate word after writing din.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign sel_onehot[gi] = (sel == SEL_W'(gi));
      assign word_next[gi]  = sel_onehot[gi] ? din : word_reg[gi];
    end
  endgenerate

  assign fill_mask_next = fill_mask_reg | sel_onehot;
  // The accept that completes the mask closes the frame, whatever the order.
  assign frame_done     = &fill_mask_next;
  assign din_ready      = (state_reg == FILL);
  assign accept         = din_valid & din_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= FILL;
      word_reg       <= '0;
      fill_mask_reg  <= '0;
      word_valid_reg <= 1'b0;
      dup_err_reg    <= 1'b0;
    end else begin
      dup_err_reg <= 1'b0;
      case (state_reg)
        FILL: begin
          if (accept) begin
            word_reg      <= word_next;
            fill_mask_reg <= fill_mask_next;
            // Flag a rewrite using the mask as it was before this write.
            dup_err_reg   <= |(fill_mask_reg & sel_onehot);
            if (frame_done) begin
              state_reg      <= HOLD;
              word_valid_reg <= 1'b1;
            end
          end
        end
        HOLD: begin
          // Clearing on the handshake edge forces one idle cycle between frames.
          if (word_ready) begin
            state_reg      <= FILL;
            word_reg       <= '0;
            fill_mask_reg  <= '0;
            word_valid_reg <= 1'b0;
          end
        end
        default: state_reg <= FILL;
      endcase
    end
  end

  assign word       = word_reg;
  assign fill_mask  = fill_mask_reg;
  assign word_valid = word_valid_reg;
  assign dup_err    = dup_err_reg;

endmodule

// File: tb/tb_demux16_deser.sv
module tb_demux16_deser;

  logic        clk = 1'b0;
  logic        rst;
  logic        din;
  logic [3:0]  sel;
  logic        din_valid;
  logic        din_ready;
  logic [15:0] word;
  logic        word_valid;
  logic        word_ready;
  logic [15:0] fill_mask;
  logic        dup_err;

  demux16_deser #(.WIDTH(16), .SEL_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .sel        (sel),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .word       (word),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .fill_mask  (fill_mask),
    .dup_err    (dup_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Scoreboard of words expected to appear when word_valid rises.
  logic [15:0] exp_q[$];
  // Reference for per-accept checks: which positions were written this frame.
  logic [15:0] mdl_mask;
  logic        wv_prev = 1'b0;

  typedef struct {
    logic [15:0] data;      // word serialized through the mux
    int          order;     // 0 in-order, 1 interleaved 15,0,14,1.., 2 reverse
    int          stall;     // HOLD cycles before word_ready
    logic [15:0] exp_word;  // word expected on the output
  } frame_t;

  frame_t tbl[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  function automatic logic [3:0] ord_sel(input int order, input int k);
    case (order)
      1:       return (k % 2 == 0) ? 4'(15 - k / 2) : 4'(k / 2);
      2:       return 4'(15 - k);
      default: return 4'(k);
    endcase
  endfunction

  // Behaviour of the 16-to-1 mux feeding the link.
  function automatic logic mux16(input logic [15:0] a, input logic [3:0] s);
    return a[s];
  endfunction

  // Monitor: pop and compare when a word is presented.
  always @(negedge clk) begin
    if (word_valid && !wv_prev) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_word", {16'h0, word}, 32'hffff_ffff);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        chk("sb_word", {16'h0, word}, {16'h0, e});
      end
    end
    wv_prev <= word_valid;
  end

  // One accept; checks dup_err, fill_mask and word_valid latency right after.
  task automatic feed(input logic [3:0] s, input logic d);
    logic exp_dup;
    din_valid = 1'b1;
    sel = s;
    din = d;
    @(posedge clk);
    #1;
    exp_dup = mdl_mask[s];
    mdl_mask[s] = 1'b1;
    chk($sformatf("dup_err sel=%0d", s), {31'h0, dup_err}, {31'h0, exp_dup});
    chk($sformatf("fill_mask sel=%0d", s), {16'h0, fill_mask}, {16'h0, mdl_mask});
    chk($sformatf("word_valid sel=%0d", s), {31'h0, word_valid}, {31'h0, &mdl_mask});
    din_valid = 1'b0;
  endtask

  // Sit in HOLD with garbage on the input side; everything must stay put.
  task automatic stall(input int n, input logic [15:0] held);
    for (int c = 0; c < n; c++) begin
      din_valid = 1'b1;
      sel = 4'($urandom_range(0, 15));
      din = 1'($urandom_range(0, 1));
      word_ready = 1'b0;
      @(posedge clk);
      #1;
      chk("hold_word", {16'h0, word}, {16'h0, held});
      chk("hold_valid_ready_dup", {29'h0, word_valid, din_ready, dup_err}, 32'h4);
      chk("hold_mask", {16'h0, fill_mask}, 32'hffff);
    end
    din_valid = 1'b0;
  endtask

  // One-cycle word_ready pulse; din_valid high at that edge must be ignored.
  task automatic handshake();
    word_ready = 1'b1;
    din_valid = 1'b1;
    sel = 4'd3;
    din = 1'b1;
    @(posedge clk);
    #1;
    word_ready = 1'b0;
    din_valid = 1'b0;
    mdl_mask = 16'h0;
    chk("turn_word", {16'h0, word}, 32'h0);
    chk("turn_mask", {16'h0, fill_mask}, 32'h0);
    chk("turn_valid_ready", {30'h0, word_valid, din_ready}, 32'h1);
  endtask

  initial begin
    logic [15:0] dv;
    tbl[0] = '{data: 16'h3f0a, order: 0, stall: 10, exp_word: 16'h3f0a};
    tbl[1] = '{data: 16'ha5c3, order: 1, stall: 2,  exp_word: 16'ha5c3};
    tbl[2] = '{data: 16'h0001, order: 0, stall: 0,  exp_word: 16'h0001};
    tbl[3] = '{data: 16'hbeef, order: 2, stall: 3,  exp_word: 16'hbeef};

    rst = 1'b1;
    din = 1'b0;
    sel = 4'd0;
    din_valid = 1'b0;
    word_ready = 1'b0;
    mdl_mask = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_word", {16'h0, word}, 32'h0);
    chk("rst_mask", {16'h0, fill_mask}, 32'h0);
    chk("rst_valid_ready_dup", {29'h0, word_valid, din_ready, dup_err}, 32'h2);

    // Reset mid-frame discards the partial frame.
    for (int k = 0; k < 6; k++) feed(4'(k), 1'b1);
    rst = 1'b1;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    din_valid = 1'b0;
    mdl_mask = 16'h0;
    chk("midrst_word", {16'h0, word}, 32'h0);
    chk("midrst_mask", {16'h0, fill_mask}, 32'h0);
    chk("midrst_valid_ready", {30'h0, word_valid, din_ready}, 32'h1);

    // Table-driven frames; frame 2 follows its predecessor's handshake directly.
    for (int i = 0; i < 4; i++) begin
      dv = tbl[i].data;
      exp_q.push_back(tbl[i].exp_word);
      for (int k = 0; k < 16; k++) begin
        logic [3:0] s;
        s = ord_sel(tbl[i].order, k);
        feed(s, dv[s]);
      end
      chk($sformatf("frame%0d_word", i), {16'h0, word}, {16'h0, tbl[i].exp_word});
      chk($sformatf("frame%0d_ready", i), {31'h0, din_ready}, 32'h0);
      stall(tbl[i].stall, tbl[i].exp_word);
      handshake();
    end

    // Duplicate write: last write wins, single dup_err pulse.
    exp_q.push_back(16'hffbf);
    feed(4'd6, 1'b1);
    feed(4'd6, 1'b0);
    for (int k = 0; k < 16; k++) if (k != 6) feed(4'(k), 1'b1);
    chk("dup_frame_word", {16'h0, word}, 32'hffbf);
    handshake();

    // Mux loopback: A=3f0a stepped through S=0..15.
    dv = 16'h3f0a;
    exp_q.push_back(16'h3f0a);
    for (int k = 0; k < 16; k++) feed(4'(k), mux16(dv, 4'(k)));
    chk("loopback_word", {16'h0, word}, 32'h3f0a);
    handshake();

    @(negedge clk);
    chk("sb_drained", exp_q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
